// File: rtl/run_control_pkg.sv
// Shared types and helpers for the stopwatch run-control slice.
// Holds the FSM state encoding, the timebase divider and a clog2 helper.

package run_control_pkg;

    // State encoding is also driven out on the state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Clock cycles per count-enable tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2_f(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/run_control_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level filter,
// and a one-cycle press pulse on each accepted 0->1 transition.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   btn_raw  asynchronous raw button, active-high
//   level    accepted (debounced) button level
//   press_p  one-cycle pulse when level is accepted as pressed

module btn_debounce
    import run_control_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press_p
);

    localparam int CW = clog2_f(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter only advances while the synchronized level disagrees
    // with the accepted one; any agreeing cycle starts the wait over,
    // so contact bounce never reaches the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            press_p <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            press_p <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level   <= sync2;
                    cnt     <= '0;
                    // Only presses are reported; releases are silent.
                    press_p <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/run_control.sv
// Stopwatch run/pause/clear controller and gated counting timebase.
// Counting can only start while ready is high; losing ready pauses.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   ready        ready indication, synchronous to clk
//   btn_start    raw start/stop button, asynchronous, active-high
//   btn_clear    raw clear button, asynchronous, active-high
//   run          high while in RUN
//   tick         one-cycle count enable to the time counter
//   clear_pulse  one-cycle clear to the time counter
//   state        FSM state (IDLE=0, ARMED=1, RUN=2, PAUSE=3)

module run_control
    import run_control_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 100,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic       run,
    output logic       tick,
    output logic       clear_pulse,
    output logic [1:0] state
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int DW  = clog2_f(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t        st;
    logic [DW-1:0] div_cnt;

    logic start_p;
    logic clear_p;
    logic start_level;
    logic clear_level;
    logic unused_levels;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_start (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_start),
        .level   (start_level),
        .press_p (start_p)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .level   (clear_level),
        .press_p (clear_p)
    );

    // Debounced levels are not needed here; only the press pulses are.
    assign unused_levels = start_level ^ clear_level;

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_IDLE;
            run         <= 1'b0;
            tick        <= 1'b0;
            clear_pulse <= 1'b0;
            div_cnt     <= '0;
        end else begin
            tick        <= 1'b0;
            clear_pulse <= 1'b0;

            // The divider advances on every cycle spent in RUN,
            // including the cycle that leaves RUN, so a pause
            // freezes it one step past the last running count.
            if (st == ST_RUN) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    tick    <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            unique case (st)
                ST_IDLE: begin
                    if (ready) begin
                        st <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!ready) begin
                        st <= ST_IDLE;
                    end else if (clear_p) begin
                        clear_pulse <= 1'b1;
                        div_cnt     <= '0;
                    end else if (start_p) begin
                        // Fresh start: full period to the first tick.
                        st      <= ST_RUN;
                        run     <= 1'b1;
                        div_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // Start/stop wins over clear while running.
                    if (!ready || start_p) begin
                        st  <= ST_PAUSE;
                        run <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (clear_p) begin
                        st          <= ST_IDLE;
                        clear_pulse <= 1'b1;
                        div_cnt     <= '0;
                    end else if (start_p && ready) begin
                        // Resume keeps the partial period.
                        st  <= ST_RUN;
                        run <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with a small divider and debounce window.
// Reset/idle vectors come from a table; run/pause corners from a timeline.

module tb_run_control;

    logic       clk;
    logic       rst;
    logic       ready;
    logic       btn_start;
    logic       btn_clear;
    logic       run;
    logic       tick;
    logic       clear_pulse;
    logic [1:0] state;

    int nvec;
    int nerr;

    run_control #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .DEB_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .btn_start   (btn_start),
        .btn_clear   (btn_clear),
        .run         (run),
        .tick        (tick),
        .clear_pulse (clear_pulse),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       bs;
        logic       bc;
        logic [1:0] st;
        logic       run;
        logic       tick;
        logic       clr;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string nm, input int k,
                       input logic [1:0] act, input logic [1:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s at step %0d: got %0d, expected %0d",
                     nm, k, act, exp_v);
        end
    endtask

    // Timeline after the table; step k's inputs are sampled at edge k
    // and the checked outputs are those just after that edge.
    function automatic logic rst_at(input int k);
        return k == 191;
    endfunction

    function automatic logic ready_at(input int k);
        if (k >= 60 && k <= 71) return 1'b0;
        if (k >= 138 && k <= 139) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic bs_at(input int k);
        if (k >= 1 && k <= 20) return 1'b1;
        if (k >= 28 && k <= 35) return 1'b1;
        if (k >= 45 && k <= 52) return 1'b1;
        if (k >= 62 && k <= 69) return 1'b1;
        if (k >= 78 && k <= 85) return 1'b1;
        if (k >= 93 && k <= 100) return 1'b1;
        if (k >= 108 && k <= 115) return 1'b1;
        if (k >= 142 && k <= 171) return (((k - 142) / 2) % 2) == 1;
        if (k >= 172 && k <= 179) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic bc_at(input int k);
        if (k >= 93 && k <= 100) return 1'b1;
        if (k >= 108 && k <= 115) return 1'b1;
        if (k >= 123 && k <= 130) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] exp_state(input int k);
        if (k <= 6) return 2'd1;
        if (k <= 33) return 2'd2;
        if (k <= 50) return 2'd3;
        if (k <= 59) return 2'd2;
        if (k <= 83) return 2'd3;
        if (k <= 98) return 2'd2;
        if (k <= 113) return 2'd3;
        if (k == 114) return 2'd0;
        if (k <= 137) return 2'd1;
        if (k <= 139) return 2'd0;
        if (k <= 177) return 2'd1;
        if (k <= 190) return 2'd2;
        if (k == 191) return 2'd0;
        return 2'd1;
    endfunction

    function automatic logic exp_tick(input int k);
        return k == 17 || k == 27 || k == 54 || k == 88 ||
               k == 98 || k == 188;
    endfunction

    function automatic logic exp_clr(input int k);
        return k == 114 || k == 129;
    endfunction

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst       = 1'b1;
        ready     = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;

        // Reset with buttons wiggling, then an ignored press in IDLE,
        // its release, and finally ready arming the controller.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 3; i <= 10; i++) begin
            tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        end
        for (int i = 11; i <= 18; i++) begin
            tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        end
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            rst       = tbl[i].rst;
            ready     = tbl[i].rdy;
            btn_start = tbl[i].bs;
            btn_clear = tbl[i].bc;
            @(posedge clk);
            #1;
            chk("tbl_state", i, state, tbl[i].st);
            chk("tbl_run", i, {1'b0, run}, {1'b0, tbl[i].run});
            chk("tbl_tick", i, {1'b0, tick}, {1'b0, tbl[i].tick});
            chk("tbl_clear", i, {1'b0, clear_pulse}, {1'b0, tbl[i].clr});
        end

        // Start, pause at count 6, resume, ready loss, start blocked
        // without ready, simultaneous presses, clear in ARMED, ready
        // drop in ARMED, bounce, and reset while running.
        for (int k = 1; k <= 194; k++) begin
            rst       = rst_at(k);
            ready     = ready_at(k);
            btn_start = bs_at(k);
            btn_clear = bc_at(k);
            @(posedge clk);
            #1;
            chk("state", k, state, exp_state(k));
            chk("run", k, {1'b0, run},
                {1'b0, exp_state(k) == 2'd2});
            chk("tick", k, {1'b0, tick}, {1'b0, exp_tick(k)});
            chk("clear_pulse", k, {1'b0, clear_pulse},
                {1'b0, exp_clr(k)});
            if (k == 40) begin
                chk("div_held", k, dut.div_cnt[1:0], 2'd3);
                chk("div_held_hi", k, dut.div_cnt[3:2], 2'd1);
            end
            if (k == 114) begin
                chk("div_cleared", k, dut.div_cnt[1:0], 2'd0);
                chk("div_cleared_hi", k, dut.div_cnt[3:2], 2'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/run_control.md
Name: run_control

Overview:
- Consumer end of the ready indication: takes `ready` and the front-panel buttons and produces the stopwatch's run/pause/clear control.
- Generates the gated counting timebase.
- Counting may start only while `ready` is asserted; loss of `ready` forces a pause.
- Sits between the ready generator and the BCD time counter / display path.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 100, count-enable rate in Hz (centiseconds); DIV = CLK_HZ/TICK_HZ, must be >= 2
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (>= 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ready  input  1  ready indication from the ready generator (synchronous to clk)
btn_start  input  1  raw start/stop pushbutton, asynchronous, active-high
btn_clear  input  1  raw clear pushbutton, asynchronous, active-high
run  output  1  high while in RUN
tick  output  1  one-cycle count enable to the time counter
clear_pulse  output  1  one-cycle synchronous clear to the time counter
state  output  2  current FSM state encoding (IDLE=0, ARMED=1, RUN=2, PAUSE=3)

Behaviour:
- One clock domain (`clk`). Reset is synchronous and active-high (`rst`); all flops reset on the `clk` edge where `rst`=1.
- Reset values:
  - state=IDLE; run=0, tick=0, clear_pulse=0.
  - Divider count=0.
  - Debouncer sync flops, stable levels and counters = 0 (buttons treated as released).
- Button path, per button:
  - 2-flop synchronizer, then stable-level counter.
  - When the synchronized level differs from the accepted level for DEB_CYCLES consecutive cycles, the accepted level updates. Any mismatch-free cycle restarts the counter.
  - A 0->1 transition of the accepted level gives a 1-cycle press pulse: start_p or clear_p.
  - Latency from raw edge to pulse = 2 + DEB_CYCLES cycles.
  - Releases produce no pulse. A held button produces exactly one pulse.
- FSM transitions, registered; outputs update the cycle after the causing pulse:
  - IDLE: ready=1 -> ARMED. Pulses ignored.
  - ARMED:
    - ready=0 -> IDLE.
    - else clear_p -> clear_pulse, stay ARMED.
    - else start_p -> RUN, with divider count forced to 0.
  - RUN:
    - ready=0 -> PAUSE.
    - else start_p -> PAUSE.
    - clear_p ignored.
  - PAUSE:
    - clear_p -> IDLE with clear_pulse (takes priority over start_p).
    - else start_p and ready=1 -> RUN; divider NOT reset, so it resumes mid-period.
    - start_p with ready=0 ignored.
- Simultaneous start_p and clear_p:
  - ARMED and PAUSE: clear wins, start dropped.
  - RUN: start wins, clear dropped.
- Outputs:
  - run = (state==RUN), registered.
  - clear_pulse is high for exactly 1 cycle per accepted clear.
- Divider:
  - Counts 0..DIV-1 only in RUN.
  - tick=1 for one cycle when count==DIV-1 in RUN; count then wraps to 0.
  - First tick after ARMED->RUN occurs DIV cycles after run rises.
  - Holds its value in PAUSE. Cleared to 0 on clear_pulse, on entry to RUN from ARMED, and on rst.
  - Width = clog2(DIV).
- rst mid-RUN: next cycle state=IDLE and all outputs 0. No clear_pulse is emitted; the downstream counter is reset by its own rst.

Decomposition:
- Shared package holds:
  - 2-bit state localparams ST_IDLE/ST_ARMED/ST_RUN/ST_PAUSE.
  - DIV computation function.
  - clog2 helper.
- Natural sub-module: `btn_debounce` (params DEB_CYCLES; ports clk, rst, btn_raw, level, press_p). Instantiated twice.
- FSM and divider stay in run_control.

Test Plan (sim params CLK_HZ=1000, TICK_HZ=100 -> DIV=10; DEB_CYCLES=4):
1. rst high 3 cycles, ready=0, buttons toggled -> state=0, run=0, tick=0, clear_pulse=0 throughout; state stays IDLE after rst drops until ready=1, then state=1 next cycle.
2. ARMED, btn_start held 20 cycles -> single start_p at 6 cycles after press; state=2 and run=1 next cycle; tick pulses every 10 cycles, first 10 cycles after run rises; holding button gives no further transitions.
3. RUN at divider count=6, press start -> PAUSE, no ticks while paused; press start again -> RUN, first tick 3 cycles after run rises (resume from 7), then every 10.
4. RUN, deassert ready -> state=3 next cycle; press start with ready=0 -> stays PAUSE; ready=1 then start -> RUN.
5. PAUSE, btn_start and btn_clear pressed same cycle -> one clear_pulse, state=0, divider=0, no RUN entry; repeat in RUN -> state=3, no clear_pulse.
6. Bounce: btn_start toggling every 2 cycles for 30 cycles then steady 1 -> no pulse during bounce; exactly one start_p 6 cycles after steady level begins.
